jtdsp16_cache: RTL and testbench
================================

Name: jtdsp16_cache

Overview:
- Instruction-cache sequencer for the DSP16 `do K` / `redo K` loop instructions.
- First pass (LOAD): captures up to 15 instructions as they are fetched from ROM.
- Then replays them from its own storage for the remaining iterations, holding the ROM AAU program counter meanwhile.
- Sits between the ROM/XAAU fetch path and the control decoder. It drives `cache_dout`, `cache_sel` and `pc_halt` and blocks interrupts while a loop is active.

Parameters:
- NMAX, 15, number of cache entries (entry index is 4 bits).
- KW, 7, width of loop count K (1..127).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable. All state updates only on clk rising edge with cen=1.
- do_en  in  1  decoder strobe: `do K` instruction accepted this cycle
- redo_en  in  1  decoder strobe: `redo K` instruction accepted this cycle
- ni  in  4  instruction count N of the loop body, 1..15
- k  in  KW  iteration count K
- inst_done  in  1  one pulse per completed instruction in the loop body
- rom_dout  in  16  instruction word currently fetched from ROM
- cache_dout  out  16  instruction word replayed from cache
- cache_sel  out  1  1: decoder takes its instruction from `cache_dout` instead of `rom_dout`
- pc_halt  out  1  1: XAAU must not advance the PC
- no_irq  out  1  interrupt acceptance inhibited
- busy  out  1  loop in progress (LOAD or REPLAY)
- cache_valid  out  1  cache holds a complete body usable by `redo`

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, iter=0, nreg=0, cache_valid=0. All outputs 0; `cache_dout`=0. Entry contents are don't-care after reset.
- States: IDLE, LOAD, REPLAY.

IDLE:
- `do_en` with ni≠0 and k≠0: latch nreg=ni, idx=0, cache_valid=0.
  - k=1: iter=0, go to LOAD (single pass, no replay).
  - Otherwise: iter=k-1, go to LOAD.
- `redo_en` with cache_valid=1 and k≠0: iter=k, idx=0, go to REPLAY.
- Ignored cases, all no-ops with no state change:
  - `redo_en` with cache_valid=0.
  - ni=0 or k=0.
  - `do_en` and `redo_en` together (illegal decode).

LOAD:
- cache_sel=0, pc_halt=0, busy=1, no_irq=1.
- On `inst_done`: entry[idx]=rom_dout, idx=idx+1.
- When idx reaches nreg-1 and `inst_done`:
  - Set cache_valid=1, idx=0.
  - If iter=0, go to IDLE; else go to REPLAY.
- The PC has already advanced past the loop body at the end of LOAD.

REPLAY:
- cache_sel=1, pc_halt=1, busy=1, no_irq=1. `cache_dout`=entry[idx] (combinational read).
- On `inst_done`: idx=idx+1.
- At idx=nreg-1 with `inst_done`:
  - idx=0, iter=iter-1.
  - If iter was 1, go to IDLE. Outputs drop the next cycle, and the PC resumes at the instruction after the body.

Common rules:
- `do_en` and `redo_en` are ignored while busy; nested loops are unsupported.
- `inst_done` is ignored in IDLE.
- `cache_dout` is held at 0 outside REPLAY.
- `cache_sel`, `pc_halt`, `no_irq` and `busy` are registered and change only on cen edges.
- Latency: the first REPLAY word is on `cache_dout` in the same cycle the state becomes REPLAY.
- Total body executions: `do K` = K (1 from ROM + K-1 from cache). `redo K` = K, all from cache.
- A new `do` overwrites the cache. cache_valid stays 0 until its LOAD pass completes.
- rst asserted mid-LOAD or mid-REPLAY: immediate return to IDLE with cache_valid=0. A later `redo` is ignored.
- ni=1: each `inst_done` completes a full iteration.
- k=127: iter counter must not overflow (KW bits).

Test Plan:
- `do` ni=3, k=3, ROM words A1,A2,A3 -> LOAD stores 3 words, then 6 REPLAY `inst_done` pulses output A1,A2,A3,A1,A2,A3 with cache_sel=pc_halt=1. Returns to IDLE with cache_valid=1.
- After the above, `redo` k=2 -> 6 words A1..A3 ×2 from cache, pc_halt=1 throughout, no ROM capture.
- `redo` k=4 after reset (cache_valid=0) -> no state change, busy=0. Also `do` with ni=0 or k=0 -> ignored.
- `do` ni=15, k=127 -> 15 captures, then 126×15 replays. The iteration counter ends exactly at IDLE; the last word equals entry[14].
- `do` ni=1, k=1 -> single LOAD pass; REPLAY never entered; cache_valid=1 after one `inst_done`.
- rst pulsed mid-REPLAY (idx=2, iter=5) -> all outputs 0 asynchronously, cache_valid=0. A `do_en` arriving while busy earlier in the run is ignored.

Source files
------------

// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache: loop instruction cache for DSP16 `do K` / `redo K`.
// The first pass of a `do` loop runs from ROM while each completed
// instruction word is captured. Later iterations replay the captured body
// from local storage while the ROM program counter is held.
//
// Strobe semantics: do_en, redo_en and inst_done are single-cycle
// qualifiers sampled only on a rising clk edge with cen=1. There is no
// back-pressure: a strobe that arrives while the block cannot act on it
// (busy, illegal combination, zero count) is dropped without side effects.
module jtdsp16_cache #(
   parameter int NMAX = 15,
   parameter int KW   = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          do_en,
   input  logic          redo_en,
   input  logic [3:0]    ni,
   input  logic [KW-1:0] k,
   input  logic          inst_done,
   input  logic [15:0]   rom_dout,
   output logic [15:0]   cache_dout,
   output logic          cache_sel,
   output logic          pc_halt,
   output logic          no_irq,
   output logic          busy,
   output logic          cache_valid
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      REPLAY = 2'd2
   } state_t;

   state_t          state;
   logic [3:0]      idx;
   logic [3:0]      nreg;
   logic [KW-1:0]   iter;
   logic [15:0]     mem [0:NMAX-1];

   logic            last_inst;
   logic            do_ok;
   logic            redo_ok;

   // Last instruction of the body: this inst_done closes one iteration.
   assign last_inst = idx == (nreg - 4'd1);

   // Legal loop starts. Simultaneous do/redo is an illegal decode and
   // is rejected, as are zero instruction or iteration counts.
   assign do_ok   = do_en && !redo_en && (ni != 4'd0) && (k != '0);
   assign redo_ok = redo_en && !do_en && cache_valid && (k != '0);

   // Replay word is read combinationally so it is valid in the very
   // cycle the state becomes REPLAY; it reads as zero elsewhere.
   assign cache_dout = (state == REPLAY) ? mem[idx] : 16'd0;

   // Body capture during the ROM pass. Contents need no reset because
   // cache_valid gates every later use.
   always_ff @(posedge clk) begin
      if (cen && state == LOAD && inst_done) begin
         mem[idx] <= rom_dout;
      end
   end

   // Loop sequencer with registered decoder/XAAU control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 4'd0;
         iter        <= '0;
         nreg        <= 4'd0;
         cache_valid <= 1'b0;
         cache_sel   <= 1'b0;
         pc_halt     <= 1'b0;
         no_irq      <= 1'b0;
         busy        <= 1'b0;
      end else if (cen) begin
         case (state)
            IDLE: begin
               if (do_ok) begin
                  // k=1 gives iter=0: a single ROM pass with no replay.
                  nreg        <= ni;
                  idx         <= 4'd0;
                  iter        <= k - KW'(1);
                  cache_valid <= 1'b0;
                  state       <= LOAD;
                  busy        <= 1'b1;
                  no_irq      <= 1'b1;
                  cache_sel   <= 1'b0;
                  pc_halt     <= 1'b0;
               end else if (redo_ok) begin
                  // All K iterations of a redo come from the cache.
                  iter      <= k;
                  idx       <= 4'd0;
                  state     <= REPLAY;
                  busy      <= 1'b1;
                  no_irq    <= 1'b1;
                  cache_sel <= 1'b1;
                  pc_halt   <= 1'b1;
               end
            end

            LOAD: begin
               if (inst_done) begin
                  if (last_inst) begin
                     // PC is already past the body; body is now reusable.
                     cache_valid <= 1'b1;
                     idx         <= 4'd0;
                     if (iter == '0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        no_irq <= 1'b0;
                     end else begin
                        state     <= REPLAY;
                        cache_sel <= 1'b1;
                        pc_halt   <= 1'b1;
                     end
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            REPLAY: begin
               if (inst_done) begin
                  if (last_inst) begin
                     idx  <= 4'd0;
                     iter <= iter - KW'(1);
                     if (iter == KW'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        no_irq    <= 1'b0;
                        cache_sel <= 1'b0;
                        pc_halt   <= 1'b0;
                     end
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               no_irq    <= 1'b0;
               cache_sel <= 1'b0;
               pc_halt   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtdsp16_cache.sv
// tb_jtdsp16_cache: scoreboard bench for the loop instruction cache.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_jtdsp16_cache;

   logic        clk;
   logic        rst;
   logic        cen;
   logic        do_en;
   logic        redo_en;
   logic [3:0]  ni;
   logic [6:0]  k;
   logic        inst_done;
   logic [15:0] rom_dout;
   logic [15:0] cache_dout;
   logic        cache_sel;
   logic        pc_halt;
   logic        no_irq;
   logic        busy;
   logic        cache_valid;

   int          n_checks;
   int          n_fail;
   logic [15:0] body [15];
   logic [15:0] exp_q [$];

   jtdsp16_cache #(.NMAX(15), .KW(7)) dut (
      .clk         (clk),
      .rst         (rst),
      .cen         (cen),
      .do_en       (do_en),
      .redo_en     (redo_en),
      .ni          (ni),
      .k           (k),
      .inst_done   (inst_done),
      .rom_dout    (rom_dout),
      .cache_dout  (cache_dout),
      .cache_sel   (cache_sel),
      .pc_halt     (pc_halt),
      .no_irq      (no_irq),
      .busy        (busy),
      .cache_valid (cache_valid)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One-cycle decoder strobe; returns on the next falling edge.
   task automatic pulse_cmd(input logic d, input logic r, input logic [3:0] n, input logic [6:0] kk);
      do_en   = d;
      redo_en = r;
      ni      = n;
      k       = kk;
      @(negedge clk);
      do_en   = 1'b0;
      redo_en = 1'b0;
   endtask

   // ROM pass: one word per inst_done; the body model remembers each word.
   task automatic load_body(input int n, input bit fixed);
      for (int i = 0; i < n; i++) begin
         check("load_busy",  busy, 1);
         check("load_sel",   cache_sel, 0);
         check("load_halt",  pc_halt, 0);
         check("load_noirq", no_irq, 1);
         check("load_valid", cache_valid, 0);
         check("load_dout",  cache_dout, 0);
         body[i]   = fixed ? (16'hA001 + 16'(i)) : 16'($urandom);
         rom_dout  = body[i];
         inst_done = 1'b1;
         @(negedge clk);
      end
      inst_done = 1'b0;
      rom_dout  = 16'($urandom);
   endtask

   // Replay: expected words queued per iteration, popped as DUT emits them.
   // Random gaps either idle inst_done or assert it with cen low.
   task automatic replay(input int iters, input int n);
      for (int it = 0; it < iters; it++) begin
         for (int j = 0; j < n; j++) exp_q.push_back(body[j]);
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               cen       = 1'($urandom_range(0, 1));
               inst_done = !cen;
               rom_dout  = 16'($urandom);
               @(negedge clk);
               cen = 1'b1;
            end
            check("rep_sel",  cache_sel, 1);
            check("rep_halt", pc_halt, 1);
            check("rep_busy", busy, 1);
            check("rep_dout", cache_dout, exp_q.pop_front());
            inst_done = 1'b1;
            @(negedge clk);
         end
      end
      inst_done = 1'b0;
   endtask

   task automatic end_idle(input logic vexp);
      check("idle_busy",  busy, 0);
      check("idle_sel",   cache_sel, 0);
      check("idle_halt",  pc_halt, 0);
      check("idle_noirq", no_irq, 0);
      check("idle_dout",  cache_dout, 0);
      check("idle_valid", cache_valid, vexp);
      check("idle_qempty", exp_q.size(), 0);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      cen       = 1'b1;
      do_en     = 1'b0;
      redo_en   = 1'b0;
      ni        = 4'd0;
      k         = 7'd0;
      inst_done = 1'b0;
      rom_dout  = 16'd0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      end_idle(1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Ignored commands: redo without valid cache, zero counts, do+redo
      pulse_cmd(1'b0, 1'b1, 4'd3, 7'd4);
      check("redo_novalid_busy", busy, 0);
      check("redo_novalid_sel", cache_sel, 0);
      pulse_cmd(1'b1, 1'b0, 4'd0, 7'd3);
      check("do_ni0_busy", busy, 0);
      pulse_cmd(1'b1, 1'b0, 4'd3, 7'd0);
      check("do_k0_busy", busy, 0);
      pulse_cmd(1'b1, 1'b1, 4'd3, 7'd3);
      check("do_redo_busy", busy, 0);
      end_idle(1'b0);

      // do ni=3 k=3 with A001..A003; cen-low inst_done and a nested do are ignored
      pulse_cmd(1'b1, 1'b0, 4'd3, 7'd3);
      check("do3_busy", busy, 1);
      cen       = 1'b0;
      inst_done = 1'b1;
      rom_dout  = 16'hFFFF;
      @(negedge clk);
      cen       = 1'b1;
      inst_done = 1'b0;
      pulse_cmd(1'b1, 1'b0, 4'd5, 7'd9);
      check("nested_do_sel", cache_sel, 0);
      load_body(3, 1'b1);
      replay(2, 3);
      end_idle(1'b1);

      // redo k=2: all from cache, ROM changes must not be captured
      pulse_cmd(1'b0, 1'b1, 4'd3, 7'd2);
      replay(2, 3);
      end_idle(1'b1);

      // do ni=1 k=1: single ROM pass, REPLAY never entered
      pulse_cmd(1'b1, 1'b0, 4'd1, 7'd1);
      load_body(1, 1'b0);
      end_idle(1'b1);

      // do ni=15 k=127: full cache, maximum iteration count
      pulse_cmd(1'b1, 1'b0, 4'd15, 7'd127);
      load_body(15, 1'b0);
      replay(126, 15);
      end_idle(1'b1);

      // do ni=5 k=7, then async reset at idx=2 with iter=5
      pulse_cmd(1'b1, 1'b0, 4'd5, 7'd7);
      load_body(5, 1'b0);
      replay(1, 5);
      for (int j = 0; j < 2; j++) begin
         check("mid_dout", cache_dout, body[j]);
         inst_done = 1'b1;
         @(negedge clk);
      end
      inst_done = 1'b0;
      check("mid_idx2_dout", cache_dout, body[2]);
      #2 rst = 1'b1;
      #1;
      end_idle(1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulse_cmd(1'b0, 1'b1, 4'd5, 7'd2);
      check("redo_after_rst_busy", busy, 0);
      end_idle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
